serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// built around a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   // state | meaning
   // IDLE  | waiting for start; diff/bout hold the last result
   // SHIFT | one operand bit pair consumed per clock, WIDTH clocks total
   // DONE  | one-cycle result-valid pulse; start here launches back-to-back
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   a_sh, b_sh, res_sh;
   logic               borrow;
   logic [CNT_W-1:0]   cnt;
   logic               ai, bi, d, borrow_nxt;
   logic               accept, last;

   assign ai         = a_sh[0];
   assign bi         = b_sh[0];
   assign d          = ai ^ bi ^ borrow;
   assign borrow_nxt = (~ai & bi) | (~(ai ^ bi) & borrow);
   assign last       = (cnt == CNT_W'(WIDTH - 1));
   assign accept     = start && ((state == IDLE) || (state == DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = start ? SHIFT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Result bits enter at the MSB, so after WIDTH shifts res_sh is LSB-aligned;
   // diff is a separate register so it holds steady during the next operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         bout   <= 1'b0;
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b;
         borrow <= bin;
         cnt    <= '0;
      end else if (state == SHIFT) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         res_sh <= {d, res_sh[WIDTH-1:1]};
         borrow <= borrow_nxt;
         cnt    <= cnt + CNT_W'(1);
         if (last) begin
            diff <= {d, res_sh[WIDTH-1:1]};
            bout <= borrow_nxt;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases from the
// operating rules plus randomized operations against an integer reference.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         busy, done, bout;
   logic [W-1:0] diff;

   int n_cmp = 0;
   int n_err = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_diff(input int av, input int bv, input int bb);
      int r;
      r = av - bv - bb;
      return 32'(r & 255);
   endfunction

   function automatic logic [31:0] ref_bout(input int av, input int bv, input int bb);
      return (av < bv + bb) ? 32'd1 : 32'd0;
   endfunction

   // Launch one operation, scramble inputs while busy, check latency and result.
   task automatic run_op(input string tag, input int av, input int bv, input int bb);
      int busy_cnt;
      int n;
      @(negedge clk);
      start = 1'b1;
      a = W'(av);
      b = W'(bv);
      bin = bb[0];
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      busy_cnt = 0;
      n = 0;
      while (!done && n < 30) begin
         if (busy) busy_cnt++;
         n++;
         @(negedge clk);
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
      check({tag, "_diff"}, 32'(diff), ref_diff(av, bv, bb));
      check({tag, "_bout"}, 32'(bout), ref_bout(av, bv, bb));
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_hold_diff"}, 32'(diff), ref_diff(av, bv, bb));
   endtask

   initial begin
      int pulses;
      int t_first;
      int t_second;
      int cyc;
      bit dropped;

      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
      rst_n = 1'b1;

      run_op("d100_58", 100, 58, 0);
      run_op("d5_10", 5, 10, 0);
      run_op("d0_0_1", 0, 0, 1);
      run_op("d255_255_1", 255, 255, 1);
      run_op("d255_0_0", 255, 0, 0);

      // Second start during busy must be ignored.
      @(negedge clk);
      start = 1'b1; a = 8'd200; b = 8'd1; bin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      pulses = 0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 3) begin start = 1'b1; a = 8'd7; b = 8'd9; end
         else start = 1'b0;
         if (done) pulses++;
         @(negedge clk);
      end
      check("ign_pulses", 32'(pulses), 32'd1);
      check("ign_diff", 32'(diff), 32'd199);
      check("ign_bout", 32'(bout), 32'd0);

      // Back-to-back with start held high.
      @(negedge clk);
      start = 1'b1; a = 8'd50; b = 8'd20; bin = 1'b0;
      @(negedge clk);
      a = 8'd20; b = 8'd50;
      pulses = 0; t_first = 0; t_second = 0; dropped = 1'b0;
      for (cyc = 1; cyc <= 30; cyc++) begin
         if (pulses == 1 && !dropped) begin start = 1'b0; dropped = 1'b1; end
         if (done) begin
            pulses++;
            if (pulses == 1) begin
               t_first = cyc;
               check("b2b_diff0", 32'(diff), 32'd30);
               check("b2b_bout0", 32'(bout), 32'd0);
            end else begin
               t_second = cyc;
               check("b2b_diff1", 32'(diff), 32'd226);
               check("b2b_bout1", 32'(bout), 32'd1);
            end
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("b2b_pulses", 32'(pulses), 32'd2);
      check("b2b_spacing", 32'(t_second - t_first), 32'd9);

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      start = 1'b1; a = 8'd77; b = 8'd3; bin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("ar_busy_before", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_done", 32'(done), 32'd0);
      check("ar_diff", 32'(diff), 32'd0);
      check("ar_bout", 32'(bout), 32'd0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 2) rst_n = 1'b1;
         if (done) pulses++;
      end
      check("ar_no_done", 32'(pulses), 32'd0);
      run_op("ar_9_4", 9, 4, 0);

      // Randomized operations, biased toward operand extremes.
      for (int k = 0; k < 1500; k++) begin
         int av, bv, bb;
         av = (k % 7 == 0) ? ((k % 2 == 0) ? 0 : 255) : int'($urandom_range(255));
         bv = (k % 11 == 0) ? ((k % 3 == 0) ? 0 : 255) : int'($urandom_range(255));
         bb = int'($urandom_range(1));
         run_op("rnd", av, bv, bb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
